running_avg_threshold_monitor: RTL and testbench

RUNNING_AVG_THRESHOLD_MONITOR -- requirements
Module: running_avg_threshold_monitor

---
 rtl/running_avg_threshold_monitor_pkg.sv | 27 ++
 rtl/running_avg_threshold_monitor_event_hold_reg.sv | 55 +++++
 rtl/running_avg_threshold_monitor.sv | 157 +++++++++++++++
 tb/tb_running_avg_threshold_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/running_avg_threshold_monitor_pkg.sv
// Shared types for the running-average threshold monitor: event codes,
// externally visible state encoding and the internal FSM encoding.
package running_avg_pkg;

    typedef enum logic [1:0] {
        EV_HIGH_ENTER = 2'd0,
        EV_HIGH_EXIT  = 2'd1,
        EV_LOW_ENTER  = 2'd2,
        EV_LOW_EXIT   = 2'd3
    } event_code_e;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2
    } state_out_e;

    // Pending states are debounce phases; they look like NORMAL from outside.
    typedef enum logic [2:0] {
        FSM_NORMAL    = 3'd0,
        FSM_HIGH_PEND = 3'd1,
        FSM_HIGH      = 3'd2,
        FSM_LOW_PEND  = 3'd3,
        FSM_LOW       = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/running_avg_threshold_monitor_event_hold_reg.sv
// One-entry event holding register with valid/ready handshake and a sticky
// overflow flag for events that arrive while a stalled event is held.
module event_hold_reg
    import running_avg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  event_code_e code_i,
    input  logic        ready_i,
    output logic        valid_o,
    output event_code_e code_o,
    output logic        overflow_o
);

    logic        valid_q, valid_d;
    event_code_e code_q, code_d;
    logic        overflow_q, overflow_d;

    // Load when the slot is free or being drained this cycle; otherwise drop
    // the newcomer, keep the held event and remember that something was lost.
    always_comb begin
        valid_d    = valid_q;
        code_d     = code_q;
        overflow_d = overflow_q;
        if (load_i) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                code_d  = code_i;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register the slot; reset clears everything including the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            code_q     <= EV_HIGH_ENTER;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_o    = valid_q;
    assign code_o     = code_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/running_avg_threshold_monitor.sv
// Debounced high/low threshold monitor on a running-average stream, with
// hysteresis on alarm exit and a one-entry event output.
module running_avg_threshold_monitor
    import running_avg_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int DEBOUNCE  = 4,
    parameter int HYST      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] average_i,
    input  logic                 average_valid_i,
    input  logic [DATAWIDTH-1:0] thr_high_i,
    input  logic [DATAWIDTH-1:0] thr_low_i,
    input  logic                 event_ready_i,
    output logic                 event_valid_o,
    output logic [1:0]           event_code_o,
    output logic [1:0]           state_o,
    output logic                 overflow_o
);

    localparam int                   CNT_W  = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]     DEB_V  = CNT_W'(DEBOUNCE);
    localparam logic [DATAWIDTH-1:0] HYST_V = DATAWIDTH'(HYST);

    // A single-sample debounce would make the pending states meaningless.
    generate
        if (DEBOUNCE < 2) begin : g_bad_debounce
            $error("running_avg_threshold_monitor: DEBOUNCE must be >= 2");
        end
    endgenerate

    fsm_state_e           fsm_q, fsm_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 above_hi, below_lo;
    logic [DATAWIDTH-1:0] exit_hi_thr, exit_lo_thr;
    logic [DATAWIDTH:0]   lo_sum;
    logic                 ev_load;
    event_code_e          ev_code;
    event_code_e          ev_code_out;

    // Threshold compares and saturating hysteresis exit levels.
    always_comb begin
        above_hi    = average_i > thr_high_i;
        below_lo    = average_i < thr_low_i;
        exit_hi_thr = (thr_high_i >= HYST_V) ? (thr_high_i - HYST_V) : '0;
        lo_sum      = {1'b0, thr_low_i} + {1'b0, HYST_V};
        exit_lo_thr = lo_sum[DATAWIDTH] ? '1 : lo_sum[DATAWIDTH-1:0];
    end

    // Next-state and debounce logic; only valid samples advance anything.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        ev_load = 1'b0;
        ev_code = EV_HIGH_ENTER;
        if (average_valid_i) begin
            case (fsm_q)
                FSM_NORMAL: begin
                    // High wins when thresholds overlap.
                    if (above_hi) begin
                        fsm_d = FSM_HIGH_PEND;
                        cnt_d = CNT_W'(1);
                    end else if (below_lo) begin
                        fsm_d = FSM_LOW_PEND;
                        cnt_d = CNT_W'(1);
                    end
                end
                FSM_HIGH_PEND: begin
                    if (above_hi) begin
                        if (cnt_q + 1'b1 == DEB_V) begin
                            fsm_d   = FSM_HIGH;
                            cnt_d   = '0;
                            ev_load = 1'b1;
                            ev_code = EV_HIGH_ENTER;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        // Breaking sample is consumed, not re-judged from NORMAL.
                        fsm_d = FSM_NORMAL;
                        cnt_d = '0;
                    end
                end
                FSM_LOW_PEND: begin
                    if (below_lo) begin
                        if (cnt_q + 1'b1 == DEB_V) begin
                            fsm_d   = FSM_LOW;
                            cnt_d   = '0;
                            ev_load = 1'b1;
                            ev_code = EV_LOW_ENTER;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        fsm_d = FSM_NORMAL;
                        cnt_d = '0;
                    end
                end
                FSM_HIGH: begin
                    if (average_i <= exit_hi_thr) begin
                        fsm_d   = FSM_NORMAL;
                        ev_load = 1'b1;
                        ev_code = EV_HIGH_EXIT;
                    end
                end
                FSM_LOW: begin
                    if (average_i >= exit_lo_thr) begin
                        fsm_d   = FSM_NORMAL;
                        ev_load = 1'b1;
                        ev_code = EV_LOW_EXIT;
                    end
                end
                default: begin
                    fsm_d = FSM_NORMAL;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // State and debounce registers; reset beats a same-cycle sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= FSM_NORMAL;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
        end
    end

    // External state view: pending phases report NORMAL.
    always_comb begin
        state_o = ST_NORMAL;
        case (fsm_q)
            FSM_HIGH: state_o = ST_HIGH;
            FSM_LOW:  state_o = ST_LOW;
            default:  state_o = ST_NORMAL;
        endcase
    end

    event_hold_reg u_event_hold (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ev_load),
        .code_i     (ev_code),
        .ready_i    (event_ready_i),
        .valid_o    (event_valid_o),
        .code_o     (ev_code_out),
        .overflow_o (overflow_o)
    );

    assign event_code_o = ev_code_out;

endmodule

// File: tb/tb_running_avg_threshold_monitor.sv
// Directed bench for the threshold monitor: expected events go into a queue
// when the qualifying sample is driven and are popped on each handshake.
module tb_running_avg_threshold_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] average_i;
    logic        average_valid_i;
    logic [31:0] thr_high_i;
    logic [31:0] thr_low_i;
    logic        event_ready_i;
    logic        event_valid_o;
    logic [1:0]  event_code_o;
    logic [1:0]  state_o;
    logic        overflow_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    running_avg_threshold_monitor #(
        .DATAWIDTH (32),
        .DEBOUNCE  (3),
        .HYST      (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .average_i       (average_i),
        .average_valid_i (average_valid_i),
        .thr_high_i      (thr_high_i),
        .thr_low_i       (thr_low_i),
        .event_ready_i   (event_ready_i),
        .event_valid_o   (event_valid_o),
        .event_code_o    (event_code_o),
        .state_o         (state_o),
        .overflow_o      (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set: score any handshake, advance one edge.
    task automatic cyc();
        logic [1:0] e;
        #1;
        if (event_valid_o === 1'b1 && event_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {31'd0, event_valid_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_code", {30'd0, event_code_o}, {30'd0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic samp(input logic [31:0] a);
        average_i       = a;
        average_valid_i = 1'b1;
        cyc();
        average_valid_i = 1'b0;
    endtask

    task automatic idle();
        average_valid_i = 1'b0;
        cyc();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] c,
                           input logic [1:0] s, input logic o);
        check({tag, "_valid"}, {31'd0, event_valid_o}, {31'd0, v});
        if (v) check({tag, "_code"}, {30'd0, event_code_o}, {30'd0, c});
        check({tag, "_state"}, {30'd0, state_o}, {30'd0, s});
        check({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, o});
    endtask

    initial begin
        reset           = 1'b1;
        average_i       = '0;
        average_valid_i = 1'b0;
        thr_high_i      = 32'd100;
        thr_low_i       = 32'd20;
        event_ready_i   = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_code", {30'd0, event_code_o}, 32'd0);
        chk_out("rst", 1'b0, 2'd0, 2'd0, 1'b0);
        reset = 1'b0;

        // Basic entry after three qualifying samples.
        samp(101); samp(101);
        chk_out("pend", 1'b0, 2'd0, 2'd0, 1'b0);
        exp_q.push_back(2'd0);
        samp(101);
        chk_out("hi_enter", 1'b1, 2'd0, 2'd1, 1'b0);
        idle();
        check("hi_drain", {31'd0, event_valid_o}, 32'd0);

        // Hysteresis: 93 holds, 92 exits.
        samp(93);
        chk_out("hyst_hold", 1'b0, 2'd0, 2'd1, 1'b0);
        exp_q.push_back(2'd1);
        samp(92);
        chk_out("hi_exit", 1'b1, 2'd1, 2'd0, 1'b0);
        idle();

        // Broken debounce: 101,101,100,101 gives nothing.
        samp(101); samp(101); samp(100); samp(101);
        chk_out("broken", 1'b0, 2'd0, 2'd0, 1'b0);
        samp(50);
        // Invalid gaps do not disturb debounce.
        samp(101); idle(); idle(); samp(101); idle();
        check("gap_state", {30'd0, state_o}, 32'd0);
        exp_q.push_back(2'd0);
        samp(101);
        chk_out("gap_enter", 1'b1, 2'd0, 2'd1, 1'b0);
        exp_q.push_back(2'd1);
        samp(50);
        idle();

        // Drop case: stalled consumer.
        event_ready_i = 1'b0;
        samp(101); samp(101);
        exp_q.push_back(2'd0);
        samp(101);
        chk_out("stall_enter", 1'b1, 2'd0, 2'd1, 1'b0);
        samp(50);
        chk_out("drop", 1'b1, 2'd0, 2'd0, 1'b1);
        idle();
        chk_out("drop_hold", 1'b1, 2'd0, 2'd0, 1'b1);
        event_ready_i = 1'b1;
        cyc();
        chk_out("drop_drain", 1'b0, 2'd0, 2'd0, 1'b1);

        // Reset mid-debounce, with a simultaneous valid sample.
        samp(10); samp(10);
        reset = 1'b1; average_i = 32'd10; average_valid_i = 1'b1;
        cyc();
        reset = 1'b0; average_valid_i = 1'b0;
        chk_out("mid_rst", 1'b0, 2'd0, 2'd0, 1'b0);
        samp(10);
        chk_out("post_rst", 1'b0, 2'd0, 2'd0, 1'b0);
        samp(10);
        exp_q.push_back(2'd2);
        samp(10);
        chk_out("lo_enter", 1'b1, 2'd2, 2'd2, 1'b0);
        samp(27);
        chk_out("lo_hold", 1'b0, 2'd0, 2'd2, 1'b0);
        exp_q.push_back(2'd3);
        samp(28);
        chk_out("lo_exit", 1'b1, 2'd3, 2'd0, 1'b0);
        idle();

        // Back-to-back: new event loads while the old one is accepted.
        samp(101); samp(101);
        exp_q.push_back(2'd0);
        samp(101);
        exp_q.push_back(2'd1);
        samp(50);
        chk_out("b2b", 1'b1, 2'd1, 2'd0, 1'b0);
        idle();

        // Misconfigured thresholds: high takes priority.
        thr_high_i = 32'd100; thr_low_i = 32'd200;
        samp(150); samp(150);
        exp_q.push_back(2'd0);
        samp(150);
        chk_out("misconf", 1'b1, 2'd0, 2'd1, 1'b0);
        exp_q.push_back(2'd1);
        samp(50);
        idle();

        // Saturation at zero on the high exit level.
        thr_high_i = 32'd4; thr_low_i = 32'd0;
        samp(5); samp(5);
        exp_q.push_back(2'd0);
        samp(5);
        check("sat_hi_state", {30'd0, state_o}, 32'd1);
        exp_q.push_back(2'd1);
        samp(0);
        chk_out("sat_hi_exit", 1'b1, 2'd1, 2'd0, 1'b0);
        idle();

        // Saturation at max on the low exit level.
        thr_high_i = 32'hFFFF_FFFF; thr_low_i = 32'hFFFF_FFFD;
        samp(0); samp(0);
        exp_q.push_back(2'd2);
        samp(0);
        check("sat_lo_state", {30'd0, state_o}, 32'd2);
        samp(32'hFFFF_FFFE);
        chk_out("sat_lo_hold", 1'b0, 2'd0, 2'd2, 1'b0);
        exp_q.push_back(2'd3);
        samp(32'hFFFF_FFFF);
        chk_out("sat_lo_exit", 1'b1, 2'd3, 2'd0, 1'b0);
        idle();
        idle();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
